// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_pkg
// Description : Shared FSM state encoding and default sizes for byte_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

    localparam int SER_DEPTH = 4;
    localparam int SER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/ser_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ser_fifo
// Description : DEPTH x WIDTH show-ahead FIFO with level, full and empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH + 1);
    localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_LVL_ONE  = c_LW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_LW-1:0]  r_level;
    logic             w_push;
    logic             w_pop;

    // Requests are qualified here so the caller can never over- or under-run.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_level == c_LVL_FULL);
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Buffers parallel words and shifts them out MSB-first, one bit
//               per enabled clock. Define SER_PARITY_EN to append an even
//               parity bit to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer
    import ser_pkg::*;
#(
    parameter int DEPTH = SER_DEPTH,
    parameter int WIDTH = SER_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       ser_enable,
    output logic                       serial_out,
    output logic                       serial_valid,
    output logic                       frame_start,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic             r_serial_out;
    logic             w_serial_out_nxt;
    logic             r_serial_valid;
    logic             w_serial_valid_nxt;
    logic             r_frame_start;
    logic             w_frame_start_nxt;
    logic             r_busy;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [WIDTH-1:0] w_fifo_rdata;
`ifdef SER_PARITY_EN
    logic             r_parity;
`endif

    ser_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (fifo_level)
    );

    assign in_ready = !w_fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_frame_start  <= 1'b0;
            r_busy         <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_shift        <= w_shift_nxt;
            r_cnt          <= w_cnt_nxt;
            r_serial_out   <= w_serial_out_nxt;
            r_serial_valid <= w_serial_valid_nxt;
            r_frame_start  <= w_frame_start_nxt;
            r_busy         <= (w_state_nxt != IDLE);
`ifdef SER_PARITY_EN
            if (w_pop) begin
                r_parity <= ^w_fifo_rdata;
            end
`endif
        end
    end

    // End of a frame either chains straight into the next queued word or idles.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (ser_enable) begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
`ifdef SER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_pop       = !w_fifo_empty;
                        w_state_nxt = w_fifo_empty ? IDLE : SHIFT;
`endif
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    w_pop       = !w_fifo_empty;
                    w_state_nxt = w_fifo_empty ? IDLE : SHIFT;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_shift_nxt        = r_shift;
        w_cnt_nxt          = r_cnt;
        w_serial_out_nxt   = r_serial_out;
        w_serial_valid_nxt = 1'b0;
        w_frame_start_nxt  = 1'b0;
        if (w_pop) begin
            w_shift_nxt        = w_fifo_rdata;
            w_cnt_nxt          = c_CNT_LAST;
            w_serial_out_nxt   = w_fifo_rdata[WIDTH-1];
            w_serial_valid_nxt = 1'b1;
            w_frame_start_nxt  = 1'b1;
        end else if (ser_enable && (r_state == SHIFT) && (r_cnt != '0)) begin
            w_shift_nxt        = r_shift << 1;
            w_cnt_nxt          = r_cnt - c_CNT_ONE;
            w_serial_out_nxt   = r_shift[WIDTH-2];
            w_serial_valid_nxt = 1'b1;
`ifdef SER_PARITY_EN
        end else if ((r_state == SHIFT) && (w_state_nxt == PARITY)) begin
            w_serial_out_nxt   = r_parity;
            w_serial_valid_nxt = 1'b1;
`endif
        end
    end

    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign frame_start  = r_frame_start;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serializer
// Description : Directed bench for byte_serializer with a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serializer;

    localparam int W = 8;
    localparam int D = 4;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         ser_enable = 1'b0;
    logic         in_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         frame_start;
    logic         busy;
    logic [2:0]   fifo_level;

    byte_serializer #(.DEPTH(D), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_enable   (ser_enable),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_bits[$];
    bit exp_fs[$];
    int accepted = 0;
    int consumed = 0;
    bit chk_en = 0;
    int max_lvl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_level();
        return accepted - (consumed + FL - 1) / FL;
    endfunction

    // Model: every accepted word becomes FL expected bits, MSB first.
    always @(posedge clk) begin
        if (reset && in_valid && (model_level() < D)) begin
            accepted++;
            for (int i = W - 1; i >= 0; i--) begin
                exp_bits.push_back(in_data[i]);
                exp_fs.push_back(i == W - 1);
            end
`ifdef SER_PARITY_EN
            exp_bits.push_back(^in_data);
            exp_fs.push_back(1'b0);
`endif
        end
    end

    always @(negedge clk) begin
        if (32'(fifo_level) > 32'(max_lvl)) max_lvl = int'(fifo_level);
    end

    always @(negedge clk) begin
        bit b;
        bit f;
        if (reset && chk_en) begin
            if (exp_bits.size() == 0) begin
                chk("spurious_valid", 32'(serial_valid), 32'd0);
            end else if (serial_valid) begin
                b = exp_bits.pop_front();
                f = exp_fs.pop_front();
                consumed++;
                chk("serial_out", 32'(serial_out), 32'(b));
                chk("frame_start", 32'(frame_start), 32'(f));
                chk("busy_on_bit", 32'(busy), 32'd1);
            end else begin
                chk("frame_start_idle", 32'(frame_start), 32'd0);
            end
            chk("fifo_level", 32'(fifo_level), 32'(model_level()));
            chk("in_ready", 32'(in_ready), 32'(model_level() < D));
        end
    end

    task automatic drain();
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (fifo_level == 0 && !busy && !serial_valid) break;
        end
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] cap;
        int          n_fs;
        int          run;
        int          got;

        #3 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_serial_out", 32'(serial_out), 32'd0);
        chk("rst_serial_valid", 32'(serial_valid), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk); reset = 1'b1; #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_valid", 32'(serial_valid), 32'd0);
        chk_en = 1'b1;
        ser_enable = 1'b1;

        // Single word: first bit one cycle after acceptance.
        @(posedge clk); #1;
        in_data = 8'hB4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b4_latency", 32'(serial_valid), 32'd0);
        cap = 0; n_fs = 0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk("b4_valid", 32'(serial_valid), 32'd1);
            cap = {cap[30:0], serial_out};
            n_fs += int'(frame_start);
        end
`ifdef SER_PARITY_EN
        chk("b4_bits", cap, 32'h168);
`else
        chk("b4_bits", cap, 32'hB4);
`endif
        chk("b4_fs_count", 32'(n_fs), 32'd1);
        @(negedge clk);
        chk("b4_after", 32'(serial_valid), 32'd0);
        drain();

        // Back-to-back words: one unbroken run of valid bits.
        @(posedge clk); #1;
        max_lvl = 0; run = 0;
        fork
            begin
                in_valid = 1'b1; in_data = 8'hFF;
                @(posedge clk); #1 in_data = 8'h00;
                @(posedge clk); #1 in_data = 8'hA5;
                @(posedge clk); #1 in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 10 && !serial_valid; k++) @(negedge clk);
                while (serial_valid && run < 40) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        chk("b2b_run", 32'(run), 32'(3 * FL));
        chk("b2b_peak_level", 32'(max_lvl), 32'd2);
        drain();

        // Overfill while frozen, then drain with a mid-stream pause.
        @(posedge clk); #1;
        ser_enable = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'((i + 1) * 17);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        @(posedge clk); #1;
        ser_enable = 1'b1;
        cap = 0; got = 0;
        for (int c = 0; c < 80 && got < 4 * FL; c++) begin
            @(negedge clk);
            if (serial_valid) begin
                if ((got % FL) < W) cap = {cap[30:0], serial_out};
                got++;
            end
            if (c == 13 || c == 14) chk("hold_valid", 32'(serial_valid), 32'd0);
            if (c == 12) ser_enable = 1'b0;
            if (c == 14) ser_enable = 1'b1;
        end
        chk("ovf_words", cap, 32'h11223344);
        chk("ovf_bits", 32'(got), 32'(4 * FL));
        @(negedge clk);
        chk("ovf_done", 32'(serial_valid), 32'd0);
        drain();

        // Frame length: next frame_start lands right after FL bits.
        @(posedge clk); #1;
        ser_enable = 1'b0; in_valid = 1'b1; in_data = 8'h07;
        @(posedge clk); #1 in_data = 8'h5A;
        @(posedge clk); #1 in_valid = 1'b0;
        ser_enable = 1'b1;
        @(negedge clk);
        cap = 0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            cap = {cap[30:0], serial_out};
        end
`ifdef SER_PARITY_EN
        chk("p07_bits", cap, 32'h00F);
`else
        chk("p07_bits", cap, 32'h07);
`endif
        @(negedge clk);
        chk("next_frame_start", 32'(frame_start), 32'd1);
        chk("next_frame_valid", 32'(serial_valid), 32'd1);
        drain();

        // Reset in the middle of a frame with words still queued.
        @(posedge clk); #1;
        ser_enable = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
        @(posedge clk); #1 in_data = 8'h11;
        @(posedge clk); #1 in_data = 8'h22;
        @(posedge clk); #1 in_valid = 1'b0;
        ser_enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("rst_mid_level", 32'(fifo_level), 32'd2);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        exp_bits.delete(); exp_fs.delete();
        accepted = 0; consumed = 0;
        #1;
        chk("rst_mid_valid", 32'(serial_valid), 32'd0);
        chk("rst_mid_out", 32'(serial_out), 32'd0);
        chk("rst_mid_busy0", 32'(busy), 32'd0);
        chk("rst_mid_lvl0", 32'(fifo_level), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(serial_valid), 32'd0);
        end
        chk("post_rst_level", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_serializer.md
# byte_serializer

- Feeds the pattern-matching detector: converts parallel bytes from the host side into the single-bit `input_seq` stream the detector consumes.
- Bytes are accepted through a valid/ready handshake into a small FIFO, then shifted out MSB-first, one bit per clock.
- Output bits change on the rising edge, so they are stable when the detector samples them on the falling edge.

## Interface
Parameters:
- `DEPTH`, 4, number of FIFO entries; must be a power of two, at least 2.
- `WIDTH`, 8, bits per word.

Ports:
- `clk`, input, 1, clock; all state updates on the rising edge.
- `reset`, input, 1, asynchronous, active-low reset (reset asserted when `reset`=0).
- `in_data`, input, WIDTH, word to serialize.
- `in_valid`, input, 1, `in_data` is valid.
- `in_ready`, output, 1, block can accept a word; equals !fifo_full.
- `ser_enable`, input, 1, shift enable; low freezes the shifter.
- `serial_out`, output, 1, current bit; drives detector `input_seq`.
- `serial_valid`, output, 1, `serial_out` carries a real data bit this cycle.
- `frame_start`, output, 1, high during the first bit of each word.
- `busy`, output, 1, shifter holds an unfinished word.
- `fifo_level`, output, $clog2(DEPTH+1), number of words stored.

## Operation
- Accept: `in_valid`&&`in_ready` at a rising edge writes `in_data` into the FIFO.
- When full, `in_ready`=0. A pop in the same cycle does not re-open the FIFO until the next cycle.
- FSM states: IDLE, SHIFT, and PARITY (PARITY only when parity is configured).
  - IDLE: if FIFO not empty and `ser_enable`=1, pop the word into the shift register. Drive bit WIDTH-1 with `serial_valid`=1 and `frame_start`=1, set bit counter to WIDTH-1, go to SHIFT.
  - SHIFT with `ser_enable`=1, counter>0: shift left, drive next bit, decrement counter.
  - SHIFT with `ser_enable`=1, counter==0 (last bit already out), no parity: pop the next word back-to-back if the FIFO is non-empty; otherwise go to IDLE.
  - SHIFT with `ser_enable`=1, counter==0, parity configured: go to PARITY.
  - PARITY: drive the parity bit for one cycle, then follow the same rule as SHIFT counter==0 without parity.
  - Any state with `ser_enable`=0: hold all state; `serial_valid`=0; `serial_out` holds its last value.
- `busy`=1 in SHIFT and PARITY.
- `frame_start` is high only on the cycle that drives bit WIDTH-1.
- Pointers wrap modulo DEPTH. `fifo_level` increments on push and decrements on pop; a simultaneous push and pop leaves it unchanged.

## Timing
- Reset values: `serial_out`=0, `serial_valid`=0, `frame_start`=0, `busy`=0, `in_ready`=1, `fifo_level`=0. FSM=IDLE, pointers=0.
- Latency, with `ser_enable` held at 1: a word accepted at edge k drives bit 7 after edge k+1 and bit 0 after edge k+8.
- Without parity, the next word's bit 7 follows after edge k+9 with no gap. With parity, the parity bit is driven after k+9 and the next word after k+10.
- Empty FIFO in IDLE: `serial_valid` stays 0 and no pop occurs.
- Reset asserted mid-word: everything clears immediately. The word in flight and all FIFO contents are discarded; no partial bits follow after release.
- All outputs are registered; no combinational path from inputs to outputs except `in_ready` (from `fifo_level` only).

## Configuration
- `SER_PARITY_EN` defined: after bit 0 of each word, one extra bit equal to the XOR of all WIDTH bits (even parity) is driven with `serial_valid`=1 and `frame_start`=0. Frame length is WIDTH+1.
- `SER_PARITY_EN` undefined: the PARITY state does not exist; frames are exactly WIDTH bits.

## Structure
- Shared package `ser_pkg`: FSM state enum (IDLE, SHIFT, PARITY) and default constants `SER_DEPTH`=4, `SER_WIDTH`=8.
- Sub-module `ser_fifo`: synchronous DEPTH×WIDTH FIFO with push/pop, full/empty and level outputs. `byte_serializer` instantiates it and contains the FSM and shifter.

## Test plan
- Reset check: hold `reset`=0, pulse the clock → all outputs at their reset values. Release → `in_ready`=1, `serial_valid`=0.
- Single byte 8'hB4 (parity off): serial_out reads 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting one cycle after acceptance; `frame_start` only on the first; then `serial_valid`=0.
- Back-to-back bytes 8'hFF, 8'h00, 8'hA5 pushed in consecutive cycles: 24 contiguous valid bits with no gap.
  - `fifo_level` peaks at 2: the first word is popped one cycle after push.
- Overfill: push 6 words with `ser_enable`=0 → `in_ready` drops after 4 accepts, `fifo_level`=4. Raise `ser_enable` → all 4 words come out in order; the 2 rejected words never appear.
- `SER_PARITY_EN`, byte 8'h07: 9 bits 0,0,0,0,0,1,1,1,1 (parity=1); next frame starts on the tenth cycle.
- Reset mid-frame: assert `reset`=0 after bit 3 of 8'hC3 with 2 words queued → outputs clear immediately. After release, `fifo_level`=0 and no further bits are driven.
